// File: rtl/meas_capture_fifo_if.sv
// meas_capture_fifo_if: capture-side and read-side handshake bundle for meas_capture_fifo
interface meas_capture_fifo_if #(
    parameter int DATA_W = 4,
    parameter int MEAS_W = 2
);
    logic [DATA_W-1:0] temp;
    logic [MEAS_W-1:0] sys_meas;
    logic              ld;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] D_out;
    logic [MEAS_W-1:0] T_out;
    modport master (output temp, sys_meas, ld, out_ready, input out_valid, D_out, T_out);
    modport slave  (input temp, sys_meas, ld, out_ready, output out_valid, D_out, T_out);
endinterface

// File: rtl/meas_capture_fifo.sv
// meas_capture_fifo: FWFT capture buffer for temp/sys_meas samples with drop accounting; MEAS_MINMAX_EN adds min/max tracking
module meas_capture_fifo #(
    parameter int DATA_W = 4,
    parameter int MEAS_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    meas_capture_fifo_if.slave       bus,
    input  logic                     hold,
    input  logic                     clr_stats,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
`ifdef MEAS_MINMAX_EN
    ,
    output logic [DATA_W-1:0]        min_out,
    output logic [DATA_W-1:0]        max_out
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W+MEAS_W-1:0] mem [DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic                     push;
    logic                     pop;
    logic                     drop;

    assign empty         = count == '0;
    assign full          = count == CW'(DEPTH);
    assign bus.out_valid = !empty;
    assign pop           = bus.out_valid & bus.out_ready;
    assign push          = bus.ld & !hold & (!full | pop);
    assign drop          = bus.ld & !hold & full & !pop;
    assign {bus.D_out, bus.T_out} = mem[rd_ptr];

    // sample storage, deliberately unreset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.temp, bus.sys_meas};
    end

    // pointers and occupancy
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    // drop accounting; a drop in the same cycle as clr_stats wins
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= clr_stats ? 8'd1 : (drop_cnt == 8'hff ? drop_cnt : drop_cnt + 8'd1);
        end else if (clr_stats) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

`ifdef MEAS_MINMAX_EN
    // running min/max of pushed temperatures; a push alongside clr_stats restarts from that sample
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            min_out <= '1;
            max_out <= '0;
        end else if (push && clr_stats) begin
            min_out <= bus.temp;
            max_out <= bus.temp;
        end else if (push) begin
            min_out <= bus.temp < min_out ? bus.temp : min_out;
            max_out <= bus.temp > max_out ? bus.temp : max_out;
        end else if (clr_stats) begin
            min_out <= '1;
            max_out <= '0;
        end
    end
`endif
endmodule

// File: tb/tb_meas_capture_fifo.sv
// tb_meas_capture_fifo: directed self-checking bench for meas_capture_fifo
module tb_meas_capture_fifo;
    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       hold = 1'b0;
    logic       clr_stats = 1'b0;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [7:0] drop_cnt;
`ifdef MEAS_MINMAX_EN
    logic [3:0] min_out;
    logic [3:0] max_out;
`endif
    int checks = 0;
    int errors = 0;

    meas_capture_fifo_if #(.DATA_W(4), .MEAS_W(2)) bus ();

    meas_capture_fifo #(.DATA_W(4), .MEAS_W(2), .DEPTH(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .bus       (bus.slave),
        .hold      (hold),
        .clr_stats (clr_stats),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
`ifdef MEAS_MINMAX_EN
        ,
        .min_out   (min_out),
        .max_out   (max_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] fill_t [4];
        logic [1:0] fill_m [4];
        fill_t = '{4'd3, 4'd5, 4'd9, 4'd1};
        fill_m = '{2'd1, 2'd2, 2'd3, 2'd0};
        bus.temp = '0;
        bus.sys_meas = '0;
        bus.ld = 1'b0;
        bus.out_ready = 1'b0;
        #3;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
`ifdef MEAS_MINMAX_EN
        chk("rst_min", 32'(min_out), 15);
        chk("rst_max", 32'(max_out), 0);
`endif
        tick();
        clr = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.temp = fill_t[i];
            bus.sys_meas = fill_m[i];
            bus.ld = 1'b1;
            tick();
            if (i == 0) begin
                chk("lat_valid", 32'(bus.out_valid), 1);
                chk("lat_d", 32'(bus.D_out), 3);
                chk("lat_t", 32'(bus.T_out), 1);
            end
        end
        bus.ld = 1'b0;
        chk("fill_count", 32'(count), 4);
        chk("fill_full", 32'(full), 1);
        chk("fill_d", 32'(bus.D_out), 3);
`ifdef MEAS_MINMAX_EN
        chk("fill_min", 32'(min_out), 1);
        chk("fill_max", 32'(max_out), 9);
`endif
        bus.temp = 4'd15;
        bus.ld = 1'b1;
        repeat (3) tick();
        chk("ovf_count", 32'(count), 4);
        chk("ovf_d", 32'(bus.D_out), 3);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_drop", 32'(drop_cnt), 3);
        bus.temp = 4'd6;
        bus.sys_meas = 2'd2;
        bus.out_ready = 1'b1;
        tick();
        bus.ld = 1'b0;
        chk("pp_d", 32'(bus.D_out), 5);
        chk("pp_count", 32'(count), 4);
        chk("pp_drop", 32'(drop_cnt), 3);
        tick();
        chk("drain_d9", 32'(bus.D_out), 9);
        tick();
        chk("drain_d1", 32'(bus.D_out), 1);
        tick();
        chk("drain_d6", 32'(bus.D_out), 6);
        chk("drain_t6", 32'(bus.T_out), 2);
        tick();
        chk("drain_empty", 32'(empty), 1);
        chk("drain_count", 32'(count), 0);
        chk("drain_valid", 32'(bus.out_valid), 0);
        bus.temp = 4'd7;
        bus.sys_meas = 2'd2;
        bus.ld = 1'b1;
        tick();
        bus.ld = 1'b0;
        bus.out_ready = 1'b0;
        chk("ept_valid", 32'(bus.out_valid), 1);
        chk("ept_d", 32'(bus.D_out), 7);
        chk("ept_t", 32'(bus.T_out), 2);
        chk("ept_count", 32'(count), 1);
        hold = 1'b1;
        bus.temp = 4'd0;
        repeat (5) begin
            bus.ld = 1'b1;
            tick();
            bus.ld = 1'b0;
            tick();
        end
        hold = 1'b0;
        chk("hold_count", 32'(count), 1);
        chk("hold_drop", 32'(drop_cnt), 3);
`ifdef MEAS_MINMAX_EN
        chk("hold_min", 32'(min_out), 1);
`endif
        bus.ld = 1'b1;
        bus.temp = 4'd2;
        tick();
        bus.temp = 4'd4;
        tick();
        bus.temp = 4'd8;
        tick();
        chk("refill_count", 32'(count), 4);
        bus.temp = 4'd9;
        repeat (300) tick();
        chk("sat_drop", 32'(drop_cnt), 255);
        chk("sat_ovf", 32'(overflow), 1);
`ifdef MEAS_MINMAX_EN
        chk("sat_max", 32'(max_out), 9);
`endif
        clr_stats = 1'b1;
        tick();
        chk("cs_drop", 32'(drop_cnt), 1);
        chk("cs_ovf", 32'(overflow), 1);
        chk("cs_count", 32'(count), 4);
        chk("cs_d", 32'(bus.D_out), 7);
`ifdef MEAS_MINMAX_EN
        chk("cs_min", 32'(min_out), 15);
        chk("cs_max", 32'(max_out), 0);
`endif
        bus.ld = 1'b0;
        tick();
        clr_stats = 1'b0;
        chk("cs2_drop", 32'(drop_cnt), 0);
        chk("cs2_ovf", 32'(overflow), 0);
        bus.ld = 1'b1;
        bus.temp = 4'd5;
        bus.out_ready = 1'b1;
        tick();
        chk("ms_d", 32'(bus.D_out), 2);
        chk("ms_count", 32'(count), 4);
`ifdef MEAS_MINMAX_EN
        chk("ms_min", 32'(min_out), 5);
        chk("ms_max", 32'(max_out), 5);
`endif
        #2;
        clr = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_full", 32'(full), 0);
        chk("arst_drop", 32'(drop_cnt), 0);
        chk("arst_ovf", 32'(overflow), 0);
`ifdef MEAS_MINMAX_EN
        chk("arst_min", 32'(min_out), 15);
        chk("arst_max", 32'(max_out), 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
